// File: rtl/controle_movimento.sv
// rtl/controle_movimento.sv - frame-rate motion controller for the VGA test square
// Holds the square position, bounces it off the screen edges once per frame, and takes run/pause/step/center commands.
module controle_movimento #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int SIZE  = 200,
  parameter int SPEED = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic [9:0] sq_x,
  output logic [9:0] sq_y,
  output logic       rodando,
  output logic [7:0] quiques,
  output logic       atualizado
);

  localparam logic [1:0] PARADO   = 2'd0;
  localparam logic [1:0] RODANDO  = 2'd1;
  localparam logic [1:0] ATUALIZA = 2'd2;

  localparam logic [1:0] CMD_PARAR  = 2'd0;
  localparam logic [1:0] CMD_RODAR  = 2'd1;
  localparam logic [1:0] CMD_PASSO  = 2'd2;
  localparam logic [1:0] CMD_CENTRO = 2'd3;

  localparam logic [10:0] LIM_X  = 11'(H_RES - SIZE);
  localparam logic [10:0] LIM_Y  = 11'(V_RES - SIZE);
  localparam logic [10:0] STEP   = 11'(SPEED);
  localparam logic [9:0]  CENT_X = 10'((H_RES - SIZE) / 2);
  localparam logic [9:0]  CENT_Y = 10'((V_RES - SIZE) / 2);

  logic [1:0]  state;
  logic [1:0]  ret_state;
  logic        step_pend;
  logic        dx_neg;
  logic        dy_neg;
  logic        cmd_accept;
  logic [11:0] nx;
  logic [11:0] ny;
  logic [7:0]  bounces;

  // Result packs {bounce, new direction (1 = negative), new position}.
  function automatic logic [11:0] axis_next(input logic [9:0] p, input logic neg, input logic [10:0] lim);
    logic [10:0] wide;
    logic [10:0] sum;
    logic [10:0] dif;
    wide = {1'b0, p};
    sum  = wide + STEP;
    dif  = wide - STEP;
    if (!neg) begin
      if (sum >= lim) axis_next = {1'b1, 1'b1, lim[9:0]};
      else            axis_next = {1'b0, 1'b0, sum[9:0]};
    end else begin
      if (wide <= STEP) axis_next = {1'b1, 1'b0, 10'd0};
      else              axis_next = {1'b0, 1'b1, dif[9:0]};
    end
  endfunction

  always_comb begin
    nx      = axis_next(sq_x, dx_neg, LIM_X);
    ny      = axis_next(sq_y, dy_neg, LIM_Y);
    bounces = {7'd0, nx[11]} + {7'd0, ny[11]};
  end

  // A tick in the same cycle as a command takes priority; the command simply waits.
  assign cmd_ready  = (state != ATUALIZA) && !frame_tick;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign rodando    = (state == RODANDO) || (state == ATUALIZA && ret_state == RODANDO);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= PARADO;
      ret_state  <= PARADO;
      step_pend  <= 1'b0;
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
      sq_x       <= CENT_X;
      sq_y       <= CENT_Y;
      quiques    <= 8'd0;
      atualizado <= 1'b0;
    end else begin
      atualizado <= 1'b0;
      if (state == ATUALIZA) begin
        sq_x       <= nx[9:0];
        dx_neg     <= nx[10];
        sq_y       <= ny[9:0];
        dy_neg     <= ny[10];
        quiques    <= quiques + bounces;
        state      <= ret_state;
        atualizado <= 1'b1;
      end else if (frame_tick) begin
        if (state == RODANDO) begin
          state     <= ATUALIZA;
          ret_state <= RODANDO;
        end else if (step_pend) begin
          state     <= ATUALIZA;
          ret_state <= PARADO;
          step_pend <= 1'b0;
        end
      end else if (cmd_accept) begin
        case (cmd)
          CMD_PARAR: begin
            state     <= PARADO;
            ret_state <= PARADO;
            step_pend <= 1'b0;
          end
          CMD_RODAR: state <= RODANDO;
          CMD_PASSO: if (state == PARADO) step_pend <= 1'b1;
          CMD_CENTRO: begin
            sq_x <= CENT_X;
            sq_y <= CENT_Y;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_controle_movimento.sv
// tb/tb_controle_movimento.sv - self-checking bench for controle_movimento
// Drives ticks and commands, compares against a position/direction model of the bouncing square.
module tb_controle_movimento;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int SIZE  = 200;
  localparam int SPEED = 2;
  localparam int LX    = H_RES - SIZE;
  localparam int LY    = V_RES - SIZE;
  localparam int CX    = LX / 2;
  localparam int CY    = LY / 2;

  logic       clock;
  logic       reset;
  logic       frame_tick;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic [9:0] sq_x;
  logic [9:0] sq_y;
  logic       rodando;
  logic [7:0] quiques;
  logic       atualizado;

  int n_checks = 0;
  int n_fail   = 0;

  int m_x, m_y, m_dx, m_dy, m_q;
  bit m_run, m_pend;

  controle_movimento #(.H_RES(H_RES), .V_RES(V_RES), .SIZE(SIZE), .SPEED(SPEED)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .sq_x(sq_x), .sq_y(sq_y), .rodando(rodando), .quiques(quiques),
    .atualizado(atualizado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model_reset();
    m_x = CX; m_y = CY; m_dx = 1; m_dy = 1; m_q = 0; m_run = 0; m_pend = 0;
  endfunction

  function automatic void model_axis(inout int p, inout int d, input int lim, inout int b);
    int np;
    np = p + d * SPEED;
    if (d > 0 && np >= lim) begin np = lim; d = -1; b++; end
    else if (d < 0 && np <= 0) begin np = 0; d = 1; b++; end
    p = np;
  endfunction

  function automatic void model_commit();
    int b;
    b = 0;
    model_axis(m_x, m_dx, LX, b);
    model_axis(m_y, m_dy, LY, b);
    m_q = (m_q + b) % 256;
  endfunction

  task automatic pulse_reset();
    reset = 1'b1; #2; reset = 1'b0;
    @(posedge clock); #1;
    model_reset();
  endtask

  task automatic do_tick();
    bit upd;
    upd = m_run || m_pend;
    frame_tick = 1'b1; #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL tick_ready got %0b want 0", cmd_ready); end
    @(posedge clock); #1;
    frame_tick = 1'b0;
    n_checks++;
    if (rodando !== m_run || atualizado !== 1'b0)
      begin n_fail++; $display("FAIL tick_mid rodando=%0b atualizado=%0b want %0b/0", rodando, atualizado, m_run); end
    if (upd) begin
      if (!m_run) m_pend = 0;
      model_commit();
    end
    @(posedge clock); #1;
    n_checks++;
    if (atualizado !== upd) begin n_fail++; $display("FAIL tick_pulse atualizado=%0b want %0b", atualizado, upd); end
    n_checks++;
    if (sq_x !== 10'(m_x) || sq_y !== 10'(m_y) || quiques !== 8'(m_q))
      begin n_fail++; $display("FAIL tick_pos got %0d/%0d q%0d want %0d/%0d q%0d", sq_x, sq_y, quiques, m_x, m_y, m_q); end
  endtask

  task automatic do_cmd(input logic [1:0] c);
    cmd_valid = 1'b1; cmd = c; #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready got %0b want 1", cmd_ready); end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    case (c)
      2'd0: begin m_run = 0; m_pend = 0; end
      2'd1: m_run = 1;
      2'd2: if (!m_run) m_pend = 1;
      default: begin m_x = CX; m_y = CY; end
    endcase
    n_checks++;
    if (sq_x !== 10'(m_x) || sq_y !== 10'(m_y) || quiques !== 8'(m_q) || rodando !== m_run)
      begin n_fail++; $display("FAIL cmd%0d got %0d/%0d q%0d r%0b want %0d/%0d q%0d r%0b", c, sq_x, sq_y, quiques, rodando, m_x, m_y, m_q, m_run); end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (sq_x !== 10'd220 || sq_y !== 10'd140 || quiques !== 8'd0 || rodando !== 1'b0 || cmd_ready !== 1'b1 || atualizado !== 1'b0)
      begin n_fail++; $display("FAIL reset_init got %0d/%0d q%0d r%0b rdy%0b", sq_x, sq_y, quiques, rodando, cmd_ready); end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    model_reset();
    do_cmd(2'd1);
    do_tick();
    do_tick();
    frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    reset = 1'b1; #1;
    n_checks++;
    if (sq_x !== 10'd220 || sq_y !== 10'd140 || quiques !== 8'd0 || rodando !== 1'b0 || cmd_ready !== 1'b1 || atualizado !== 1'b0)
      begin n_fail++; $display("FAIL reset_async got %0d/%0d q%0d r%0b rdy%0b", sq_x, sq_y, quiques, rodando, cmd_ready); end
    @(posedge clock); #1;
    n_checks++;
    if (atualizado !== 1'b0 || sq_x !== 10'd220) begin n_fail++; $display("FAIL reset_nocommit atualizado=%0b x=%0d want 0/220", atualizado, sq_x); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_parado_ticks();
    pulse_reset();
    repeat (5) do_tick();
    n_checks++;
    if (sq_x !== 10'd220 || sq_y !== 10'd140) begin n_fail++; $display("FAIL parado got %0d/%0d want 220/140", sq_x, sq_y); end
  endtask

  task automatic test_rodar_3();
    do_cmd(2'd1);
    repeat (3) do_tick();
    n_checks++;
    if (sq_x !== 10'd226 || sq_y !== 10'd146) begin n_fail++; $display("FAIL rodar3 got %0d/%0d want 226/146", sq_x, sq_y); end
  endtask

  task automatic test_bounce();
    pulse_reset();
    do_cmd(2'd1);
    repeat (70) do_tick();
    n_checks++;
    if (sq_x !== 10'd360 || sq_y !== 10'd280 || quiques !== 8'd1)
      begin n_fail++; $display("FAIL bounce70 got %0d/%0d q%0d want 360/280 q1", sq_x, sq_y, quiques); end
    do_tick();
    n_checks++;
    if (sq_x !== 10'd362 || sq_y !== 10'd278) begin n_fail++; $display("FAIL bounce71 got %0d/%0d want 362/278", sq_x, sq_y); end
  endtask

  task automatic test_collision();
    frame_tick = 1'b1; cmd_valid = 1'b1; cmd = 2'd3; #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL coll_ready0 got %0b want 0", cmd_ready); end
    @(posedge clock); #1;
    frame_tick = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL coll_ready1 got %0b want 0", cmd_ready); end
    model_commit();
    @(posedge clock); #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || atualizado !== 1'b1 || sq_x !== 10'(m_x) || sq_y !== 10'(m_y))
      begin n_fail++; $display("FAIL coll_commit rdy%0b upd%0b %0d/%0d want 1/1 %0d/%0d", cmd_ready, atualizado, sq_x, sq_y, m_x, m_y); end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    m_x = CX; m_y = CY;
    n_checks++;
    if (sq_x !== 10'd220 || sq_y !== 10'd140 || quiques !== 8'd1)
      begin n_fail++; $display("FAIL coll_centro got %0d/%0d q%0d want 220/140 q1", sq_x, sq_y, quiques); end
  endtask

  task automatic test_passo();
    pulse_reset();
    do_cmd(2'd2);
    do_tick();
    n_checks++;
    if (sq_x !== 10'd222 || sq_y !== 10'd142 || rodando !== 1'b0)
      begin n_fail++; $display("FAIL passo1 got %0d/%0d r%0b want 222/142 r0", sq_x, sq_y, rodando); end
    repeat (2) do_tick();
    n_checks++;
    if (sq_x !== 10'd222 || sq_y !== 10'd142 || rodando !== 1'b0)
      begin n_fail++; $display("FAIL passo3 got %0d/%0d r%0b want 222/142 r0", sq_x, sq_y, rodando); end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) do_tick();
      else if ($urandom_range(0, 3) == 0) do_cmd(2'($urandom_range(0, 3)));
      else do_cmd(2'd1);
    end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; cmd_valid = 1'b0; cmd = 2'd0;
    model_reset();
    test_reset();
    test_parado_ticks();
    test_rodar_3();
    test_bounce();
    test_collision();
    test_passo();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

endmodule

// File: doc/controle_movimento.md
# controle_movimento

Frame-rate motion controller for the VGA test square. It owns the square's top-left position (sq_x, sq_y) that the pixel painter compares against sx/sy, and advances that position once per frame with edge bounce. It accepts run/pause/step/center commands over a valid/ready handshake and sits between the VGA timing generator, which supplies the frame tick, and the colour paint logic.

## Interface
- H_RES, default 640: active width in pixels.
- V_RES, default 480: active height in pixels.
- SIZE, default 200: square side in pixels; must satisfy SIZE < H_RES and SIZE < V_RES.
- SPEED, default 2: pixels moved per axis per update; must satisfy 1 ≤ SPEED ≤ min(H_RES, V_RES) − SIZE.
- clock  in  1  pixel clock (25 MHz); all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per frame, at start of vertical blanking.
- cmd_valid  in  1  command present.
- cmd  in  2  0 = PARAR, 1 = RODAR, 2 = PASSO, 3 = CENTRO.
- cmd_ready  out  1  command accepted on an edge where cmd_valid && cmd_ready.
- sq_x  out  10  square left column, range 0..H_RES−SIZE.
- sq_y  out  10  square top row, range 0..V_RES−SIZE.
- rodando  out  1  high while in free-running mode.
- quiques  out  8  bounce counter, wraps 255→0.
- atualizado  out  1  one-cycle pulse after each position commit.

## Operation
- Reset values: sq_x = (H_RES−SIZE)/2 (220), sq_y = (V_RES−SIZE)/2 (140), dx = dy = +, state PARADO, step_pend = 0, rodando = 0, quiques = 0, atualizado = 0, cmd_ready = 1.
- States: PARADO, RODANDO, ATUALIZA. The return state (PARADO or RODANDO) is held in a register.
- Transitions:
  - RODANDO + frame_tick → ATUALIZA.
  - PARADO + frame_tick + step_pend → ATUALIZA; clear step_pend.
  - PARADO + frame_tick without step_pend: ignored.
  - ATUALIZA → return state after one cycle; commit position.
- Commands, applied on the acceptance edge:
  - PARAR: state and return state become PARADO; clear step_pend.
  - RODAR: state becomes RODANDO.
  - PASSO: in PARADO, set step_pend. In RODANDO, no effect (accepted, dropped).
  - CENTRO: reset sq_x/sq_y to their reset values. Directions, quiques and state are unchanged.
- cmd_ready = (state != ATUALIZA) && !frame_tick. This is combinational, so a tick always wins over a simultaneous command and the command waits.
- Per-axis update for x, with limit L = H_RES−SIZE (same rule for y with V_RES):
  - dx = + and x + SPEED ≥ L: x = L, dx = −, bounce.
  - dx = − and x ≤ SPEED: x = 0, dx = +, bounce.
  - Otherwise x ± SPEED.
  - Compute with 11-bit intermediates; x must never leave 0..L.
- quiques += number of bounces in the commit, 0, 1 or 2. A corner hit adds 2. Wrap modulo 256.
- rodando = (state == RODANDO) || (state == ATUALIZA && return state == RODANDO).

## Timing
- frame_tick sampled at edge N moves the state to ATUALIZA. New sq_x/sq_y/quiques are registered at edge N+1, and atualizado is high for the cycle after N+1.
- sq_x/sq_y are stable at all other times. They only change on commit, CENTRO, or reset, all of which occur during blanking in normal use.
- A frame_tick arriving while in ATUALIZA is ignored.
- CENTRO becomes visible on the outputs after its acceptance edge, with 1-cycle latency.
- Reset asserted mid-ATUALIZA: outputs take their reset values immediately. No commit happens and no atualizado pulse is produced.
- Latency from command acceptance to state change: 1 edge. cmd_ready deasserts only during ATUALIZA and tick cycles.

## Test plan
- Reset: assert reset mid-run → sq_x = 220, sq_y = 140, quiques = 0, rodando = 0, cmd_ready = 1 without waiting for a clock edge.
- PARADO, no command, 5 ticks → sq_x/sq_y stay 220/140, atualizado never pulses.
- RODAR, then 3 ticks → sq_x = 226, sq_y = 146, exactly 3 atualizado pulses, each one cycle after its tick.
- RODAR, 70 ticks → sq_y = 280, dy = −, sq_x = 360, quiques = 1. Tick 71 → sq_y = 278, sq_x = 362.
- PARADO, PASSO, then 3 ticks → sq_x = 222, sq_y = 142 after the first tick only, rodando = 0 throughout.
- Command presented on the same cycle as frame_tick → cmd_ready = 0 for that cycle and the next, command accepted on the following edge. CENTRO after movement → 220/140 with quiques unchanged.
